// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration, fixed SETUP/ACCESS transfers
// (no PREADY), read data returned with a one-cycle done pulse per requester.

`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_master_arbiter #(
  parameter int ADDR_WIDTH = `APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = `APB_DATA_WIDTH
) (
  input  logic                  PClk,
  input  logic                  Rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] PAddr,
  output logic                  PSel,
  output logic                  PEnable,
  output logic                  PWrite,
  output logic [DATA_WIDTH-1:0] PWData,
  input  logic [DATA_WIDTH-1:0] PRData
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_nxt;
  logic   last_owner;   // requester served by the most recent grant
  logic   owner;        // requester owning the transfer in flight
  logic   elig0, elig1;
  logic   grant_valid;
  logic   grant_id;

  // A requester in its done cycle is masked so its completed command is not re-granted.
  always_comb begin
    elig0       = req0 & ~done0;
    elig1       = req1 & ~done1;
    grant_valid = (state == IDLE) && (elig0 || elig1);
    grant_id    = (elig0 && elig1) ? ~last_owner : elig1;
  end

  // NOTE: every output of a combinational block gets a default first; otherwise an
  // unassigned path infers a latch.
  always_comb begin
    state_nxt = state;
    PSel      = 1'b0;
    PEnable   = 1'b0;
    case (state)
      IDLE:    if (grant_valid) state_nxt = SETUP;
      SETUP: begin
        PSel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSel      = 1'b1;
        PEnable   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge PClk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // PSel/PEnable decode straight from state, so reset drops them asynchronously.
  always_ff @(posedge PClk or posedge Rst) begin
    if (Rst) begin
      PAddr      <= '0;
      PWrite     <= 1'b0;
      PWData     <= '0;
      rdata      <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (grant_valid) begin
        owner      <= grant_id;
        last_owner <= grant_id;
        PWrite     <= grant_id ? wr1    : wr0;
        PAddr      <= grant_id ? addr1  : addr0;
        PWData     <= grant_id ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        if (!PWrite) rdata <= PRData;
        if (owner) done1 <= 1'b1;
        else       done0 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: drivers push expected commands per
// requester, a monitor checks APB phasing and pops on every done pulse.

module tb_apb_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  logic          PClk = 1'b0;
  logic          Rst  = 1'b1;
  logic          req_v   [2];
  logic          wr_v    [2];
  logic [AW-1:0] addr_v  [2];
  logic [DW-1:0] wdata_v [2];
  logic          done0, done1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] PAddr;
  logic          PSel, PEnable, PWrite;
  logic [DW-1:0] PWData;
  logic [DW-1:0] PRData;

  int checks = 0;
  int errors = 0;

  cmd_t exp_q0[$];
  cmd_t exp_q1[$];
  int   done_order[$];
  int   setup_cyc[$];

  always #5 PClk = ~PClk;

  apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .PClk(PClk), .Rst(Rst),
    .req0(req_v[0]), .req1(req_v[1]),
    .wr0(wr_v[0]), .wr1(wr_v[1]),
    .addr0(addr_v[0]), .addr1(addr_v[1]),
    .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
    .done0(done0), .done1(done1), .rdata(rdata),
    .PAddr(PAddr), .PSel(PSel), .PEnable(PEnable), .PWrite(PWrite),
    .PWData(PWData), .PRData(PRData)
  );

  // Slave read data is a fixed function of the address.
  function automatic logic [DW-1:0] rd_hash(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hA5;
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign PRData = (PSel && PEnable) ? rd_hash(PAddr) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: APB phasing, stability, and done/rdata against the scoreboard.
  initial begin
    int            sel_len = 0;
    int            cyc = 0;
    cmd_t          setup_cmd = '0;
    cmd_t          bus_cmd = '0;
    cmd_t          e;
    logic [DW-1:0] rdata_m = '0;
    logic          prev_done0 = 1'b0, prev_done1 = 1'b0;
    forever begin
      @(negedge PClk);
      cyc++;
      if (Rst) begin
        sel_len = 0; rdata_m = '0; prev_done0 = 1'b0; prev_done1 = 1'b0;
      end else begin
        if (PEnable && !PSel) check("penable_without_psel", 1, 0);
        if (PSel) begin
          sel_len++;
          check("penable_phase", PEnable, sel_len == 2);
          if (sel_len == 1) begin
            setup_cmd = '{PWrite, PAddr, PWData};
            setup_cyc.push_back(cyc);
          end else begin
            check("paddr_stable", PAddr, setup_cmd.addr);
            check("pwrite_stable", PWrite, setup_cmd.wr);
            check("pwdata_stable", PWData, setup_cmd.wdata);
            bus_cmd = setup_cmd;
          end
        end else if (sel_len != 0) begin
          check("psel_length", sel_len, 2);
          sel_len = 0;
        end
        if (done0 || done1) begin
          check("done_exclusive", done0 & done1, 0);
          check("done_single_cycle", done0 ? prev_done0 : prev_done1, 0);
          check("done_with_pending_cmd", done0 ? (exp_q0.size() != 0) : (exp_q1.size() != 0), 1);
          if (done0 ? (exp_q0.size() != 0) : (exp_q1.size() != 0)) begin
            e = done0 ? exp_q0.pop_front() : exp_q1.pop_front();
            done_order.push_back(done0 ? 0 : 1);
            check("xfer_addr", bus_cmd.addr, e.addr);
            check("xfer_wr", bus_cmd.wr, e.wr);
            if (e.wr) check("xfer_wdata", bus_cmd.wdata, e.wdata);
            else      rdata_m = rd_hash(e.addr);
            check("rdata", rdata, rdata_m);
          end
        end
        prev_done0 = done0;
        prev_done1 = done1;
      end
    end
  end

  // Issue one command and hold it until its done is seen; returns on the done edge.
  task automatic run_cmd(input int r, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit keep, input bit toggle);
    bit got = 0;
    wr_v[r] = wr; addr_v[r] = a; wdata_v[r] = d; req_v[r] = 1'b1;
    if (r == 0) exp_q0.push_back('{wr, a, d});
    else        exp_q1.push_back('{wr, a, d});
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge PClk);
      if (toggle && PSel && !PEnable) addr_v[r] = ~a;
      if (!Rst && ((r == 0) ? done0 : done1)) got = 1;
    end
    check($sformatf("done_timeout_r%0d", r), got, 1);
    @(posedge PClk); #1;
    if (!keep) req_v[r] = 1'b0;
  endtask

  task automatic rand_stream(input int r, input int n);
    int gap;
    @(posedge PClk); #1;
    gap = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      int nxt;
      repeat (gap) @(posedge PClk);
      if (gap != 0) #1;
      nxt = $urandom_range(0, 2);
      run_cmd(r, 1'($urandom_range(0, 1)), $urandom & 32'hFFFC, $urandom,
              (nxt == 0) && (k != n - 1), 0);
      gap = nxt;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int r = 0; r < 2; r++) begin
      req_v[r] = 0; wr_v[r] = 0; addr_v[r] = '0; wdata_v[r] = '0;
    end
    #12;
    check("rst_psel", PSel, 0);
    check("rst_penable", PEnable, 0);
    check("rst_paddr", PAddr, 0);
    check("rst_pwrite", PWrite, 0);
    check("rst_pwdata", PWData, 0);
    check("rst_rdata", rdata, 0);
    check("rst_done", {done1, done0}, 0);
    @(negedge PClk); Rst = 0;

    // Single read, then single write (rdata must keep the read value).
    run_cmd(0, 0, 32'h10, 32'h0, 0, 0);
    run_cmd(1, 1, 32'h04, 32'h3C, 0, 0);

    // Contention from reset: grant order 0,1,0,1, one SETUP every 3 cycles.
    @(negedge PClk); Rst = 1;
    done_order.delete(); setup_cyc.delete();
    fork
      begin run_cmd(0, 0, 32'h100, 0, 1, 0); run_cmd(0, 1, 32'h104, 32'h11, 0, 0); end
      begin run_cmd(1, 0, 32'h200, 0, 1, 0); run_cmd(1, 1, 32'h204, 32'h22, 0, 0); end
      begin repeat (2) @(negedge PClk); Rst = 0; end
    join
    check("contention_count", done_order.size(), 4);
    if (done_order.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("grant_order_%0d", i), done_order[i], i % 2);
    if (setup_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("contention_spacing", setup_cyc[i] - setup_cyc[i-1], 3);

    // Back-to-back on one requester: masked done cycle adds one IDLE.
    repeat (2) @(posedge PClk); #1;
    setup_cyc.delete();
    run_cmd(0, 0, 32'h20, 0, 1, 0);
    run_cmd(0, 1, 32'h24, 32'h77, 0, 0);
    check("b2b_setups", setup_cyc.size(), 2);
    if (setup_cyc.size() == 2) check("b2b_spacing", setup_cyc[1] - setup_cyc[0], 4);

    // Reset during ACCESS: outputs drop immediately; held request completes once.
    repeat (2) @(posedge PClk); #1;
    done_order.delete();
    fork
      run_cmd(0, 0, 32'h30, 0, 0, 0);
      begin
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge PClk);
          if (PEnable) seen = 1;
        end
        check("access_reached", seen, 1);
        #1 Rst = 1;
        #1;
        check("abort_psel", PSel, 0);
        check("abort_penable", PEnable, 0);
        check("abort_done", {done1, done0}, 0);
        check("abort_paddr", PAddr, 0);
        check("abort_rdata", rdata, 0);
        @(negedge PClk); @(negedge PClk); Rst = 0;
      end
    join
    repeat (3) @(posedge PClk);
    check("abort_single_done", done_order.size(), 1);

    // Address toggled during SETUP must not reach PAddr.
    run_cmd(1, 0, 32'h44, 0, 0, 1);

    // Randomized concurrent traffic.
    fork
      rand_stream(0, 20);
      rand_stream(1, 20);
    join
    repeat (4) @(posedge PClk);
    check("leftover_q0", exp_q0.size(), 0);
    check("leftover_q1", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master that shares a single APB bus between two internal command sources (e.g. a testbench driver and a register-configuration sequencer). It arbitrates round-robin, sequences each transfer through the APB SETUP and ACCESS phases, and returns read data with a one-cycle completion pulse. It drives the master side of the APB interface; the bus has no PREADY, so every transfer is a fixed two-phase transfer.

## Interface

- ADDR_WIDTH, default APB_ADDR_WIDTH (common root definitions): width of PAddr and requester addresses
- DATA_WIDTH, default APB_DATA_WIDTH: width of PWData, PRData and requester data
- PClk  in  1  bus clock; all state changes on the rising edge
- Rst  in  1  asynchronous, active-high reset
- req0, req1  in  1 each  requester n has a pending command
- wr0, wr1  in  1 each  1 = write, 0 = read
- addr0, addr1  in  ADDR_WIDTH each  transfer address
- wdata0, wdata1  in  DATA_WIDTH each  write data
- done0, done1  out  1 each  one-cycle completion pulse for requester n
- rdata  out  DATA_WIDTH  read data of the last completed transfer; valid while done0 or done1 is high
- PAddr  out  ADDR_WIDTH  APB address
- PSel  out  1  APB select
- PEnable  out  1  APB enable
- PWrite  out  1  APB direction
- PWData  out  DATA_WIDTH  APB write data
- PRData  in  DATA_WIDTH  APB read data

## Operation

- FSM states: IDLE, SETUP, ACCESS. Reset state IDLE.
- IDLE: eligible_n = req_n & ~done_n. None eligible -> stay IDLE. Otherwise grant one, capture its wr/addr/wdata into PWrite/PAddr/PWData, record owner, go to SETUP.
- Arbitration: only one eligible -> grant it. Both eligible -> grant the requester not served last (last-owner pointer). Pointer updates on each grant; reset value = 1, so requester 0 wins the first contention.
- SETUP: PSel=1, PEnable=0; go to ACCESS unconditionally.
- ACCESS: PSel=1, PEnable=1; go to IDLE unconditionally. At the edge leaving ACCESS: rdata <= PRData when PWrite=0 (rdata holds its previous value on writes), done_owner <= 1.
- done_n is high for exactly the IDLE cycle following ACCESS. It is cleared on the next edge.
- Requester protocol: hold req_n, wr_n, addr_n and wdata_n stable from assertion until done_n is sampled high. Drop req_n on that same edge, or keep it high to issue a new command, which is then presented with new fields. The ~done_n mask stops the just-served command from being re-granted in the done cycle.
- IDLE bus values: PSel=0, PEnable=0. PAddr, PWrite and PWData hold the last transfer's values.

## Timing

- Reset (async, immediate): state=IDLE, PSel=0, PEnable=0, PWrite=0, PAddr=0, PWData=0, rdata=0, done0=done1=0, pointer=1.
- Latency: req sampled in IDLE at edge E0. SETUP occupies cycle E0–E1, ACCESS occupies E1–E2, done is high E2–E3.
- Throughput: one transfer per 3 cycles (IDLE, SETUP, ACCESS). No back-to-back SETUP without an intervening IDLE.
- APB rules: PAddr, PWrite and PWData are stable across SETUP and ACCESS. PEnable is never high without PSel. PSel stays high for exactly 2 cycles per transfer.
- Rst asserted in SETUP or ACCESS: the transfer is aborted, no done is issued, and PSel/PEnable drop asynchronously. After release, a requester still holding req is re-arbitrated from IDLE.
- A req change mid-transfer does not affect the captured command.
- A req from the non-owner arriving during SETUP/ACCESS waits and is granted in the next IDLE, unless it is masked by its own done.

## Test plan

- Single read: req0=1, wr0=0, addr0=0x10, PRData=0xA5 during ACCESS -> PSel high 2 cycles, PEnable high in the 2nd only, PAddr=0x10, PWrite=0. done0 pulses 1 cycle with rdata=0xA5. done1 stays 0.
- Single write: req1=1, wr1=1, addr1=0x04, wdata1=0x3C -> PWrite=1, PWData=0x3C stable in SETUP and ACCESS. done1 pulses once. rdata is unchanged.
- Contention: req0 and req1 both held continuously from reset with distinct addresses -> grant order 0,1,0,1. Each transfer takes 3 cycles, with no PSel gap other than the single IDLE cycle.
- Back-to-back same requester: req0 held with a new address presented on its done edge -> second transfer starts after one IDLE plus one masked done cycle. There is no duplicate transfer of the first address.
- Reset mid-ACCESS: assert Rst during PEnable=1 -> PSel, PEnable and done drop immediately and all outputs read reset values. After release, the held req0 completes exactly once.
- Command stability: toggle addr1 during SETUP -> PAddr keeps the value captured in IDLE.
